// File: rtl/trg_run_ctrl.sv
// ---------------------------------------------------------------------------
// trg_run_ctrl
//
// Run controller for the minimum-trigger datapath. Sequences the baseline
// calculation, arms the trigger block, and holds trigger acceptance while the
// output FIFO is full. It also keeps saturating counts of accepted and
// dropped triggers for the PS-side status readout.
//
// Optional build macro:
//   TRG_RUN_CTRL_AUTO_RETRY_EN - when defined, a baseline timeout restarts the
//   baseline calculation in place rather than returning to IDLE. The run then
//   ends only on RUN_STOP.
//
// Ports:
//   AXIS_ACLK         in   clock
//   AXIS_ARESETN      in   asynchronous active-low reset
//   RUN_START         in   start run request (level or pulse)
//   RUN_STOP          in   stop run request (level or pulse), highest priority
//   BL_CALC_COMPLETE  in   baseline block done flag
//   FIFO_FULL         in   output FIFO full flag
//   START_TRG         in   one-cycle trigger-start pulse
//   S_AXIS_TVALID     in   ADC stream valid, qualifies baseline timeout count
//   O_EXEC_STATE      out  00 INIT, 01 BL_CALC, 11 TRG, 10 HOLD
//   O_BL_CALC_START   out  one-cycle pulse restarting baseline calculation
//   O_TIMER_CLR       out  one-cycle pulse clearing the time counter
//   O_TRG_EN          out  trigger acceptance enable (ARMED only)
//   O_BUSY            out  high in every state except IDLE
//   O_ERR_TIMEOUT     out  sticky baseline-timeout flag
//   O_EVENT_COUNT     out  triggers accepted while armed, saturating
//   O_DROP_COUNT      out  triggers seen while held, saturating
// ---------------------------------------------------------------------------
module trg_run_ctrl #(
    parameter int BL_TIMEOUT_LEN = 256,
    parameter int HOLDOFF_LEN    = 8,
    parameter int EVT_CNT_WIDTH  = 32,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESETN,
    input  logic                      RUN_START,
    input  logic                      RUN_STOP,
    input  logic                      BL_CALC_COMPLETE,
    input  logic                      FIFO_FULL,
    input  logic                      START_TRG,
    input  logic                      S_AXIS_TVALID,
    output logic [1:0]                O_EXEC_STATE,
    output logic                      O_BL_CALC_START,
    output logic                      O_TIMER_CLR,
    output logic                      O_TRG_EN,
    output logic                      O_BUSY,
    output logic                      O_ERR_TIMEOUT,
    output logic [EVT_CNT_WIDTH-1:0]  O_EVENT_COUNT,
    output logic [DROP_CNT_WIDTH-1:0] O_DROP_COUNT
);

    localparam int TO_W = $clog2(BL_TIMEOUT_LEN + 1);
    localparam int HO_W = $clog2(HOLDOFF_LEN + 1);

    // The encoding is the EXEC_STATE bus value itself, so the state register
    // drives the downstream blocks directly with no decode.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BL_CALC = 2'b01,
        ST_ARMED   = 2'b11,
        ST_HOLD    = 2'b10
    } state_t;

    state_t                    state_q, state_n;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_n;
    logic [HO_W-1:0]           ho_cnt_q, ho_cnt_n;
    logic                      bl_start_q, bl_start_n;
    logic                      timer_clr_q, timer_clr_n;
    logic                      trg_en_q;
    logic                      busy_q;
    logic                      err_q, err_n;
    logic [EVT_CNT_WIDTH-1:0]  evt_q, evt_n;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_n;

    logic timeout_hit;
    logic holdoff_hit;

    // The current valid sample is the one that brings the count to the limit.
    assign timeout_hit = S_AXIS_TVALID && (to_cnt_q == TO_W'(BL_TIMEOUT_LEN - 1));
    // The current low cycle is the last one of the required quiet window.
    assign holdoff_hit = !FIFO_FULL && (ho_cnt_q == HO_W'(HOLDOFF_LEN - 1));

    // Next-state and next-output logic. Every non-IDLE state checks RUN_STOP
    // first, then FIFO_FULL, then the baseline timeout, then completion.
    always_comb begin
        state_n     = state_q;
        to_cnt_n    = to_cnt_q;
        ho_cnt_n    = ho_cnt_q;
        bl_start_n  = 1'b0;
        timer_clr_n = 1'b0;
        err_n       = err_q;
        evt_n       = evt_q;
        drop_n      = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (RUN_START && !RUN_STOP) begin
                    state_n     = ST_BL_CALC;
                    bl_start_n  = 1'b1;
                    timer_clr_n = 1'b1;
                    to_cnt_n    = '0;
                    err_n       = 1'b0;
                    evt_n       = '0;
                    drop_n      = '0;
                end
            end

            ST_BL_CALC: begin
                if (RUN_STOP) begin
                    state_n = ST_IDLE;
                end else if (timeout_hit) begin
                    err_n    = 1'b1;
                    to_cnt_n = '0;
`ifdef TRG_RUN_CTRL_AUTO_RETRY_EN
                    bl_start_n = 1'b1;
`else
                    state_n = ST_IDLE;
`endif
                end else begin
                    if (S_AXIS_TVALID) begin
                        to_cnt_n = to_cnt_q + 1'b1;
                    end
                    if (BL_CALC_COMPLETE) begin
                        state_n = ST_ARMED;
                    end
                end
            end

            ST_ARMED: begin
                // Trigger enable is high this cycle, so a pulse is accepted
                // even if the state is about to change.
                if (START_TRG && (evt_q != '1)) begin
                    evt_n = evt_q + 1'b1;
                end
                if (RUN_STOP) begin
                    state_n = ST_IDLE;
                end else if (FIFO_FULL) begin
                    state_n  = ST_HOLD;
                    ho_cnt_n = '0;
                end
            end

            ST_HOLD: begin
                if (START_TRG && (drop_q != '1)) begin
                    drop_n = drop_q + 1'b1;
                end
                if (RUN_STOP) begin
                    state_n = ST_IDLE;
                end else if (FIFO_FULL) begin
                    ho_cnt_n = '0;
                end else if (holdoff_hit) begin
                    state_n  = ST_ARMED;
                    ho_cnt_n = '0;
                end else begin
                    ho_cnt_n = ho_cnt_q + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset asserts
    // asynchronously so a mid-run reset silences the outputs at once.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            ho_cnt_q    <= '0;
            bl_start_q  <= 1'b0;
            timer_clr_q <= 1'b0;
            trg_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            evt_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_n;
            to_cnt_q    <= to_cnt_n;
            ho_cnt_q    <= ho_cnt_n;
            bl_start_q  <= bl_start_n;
            timer_clr_q <= timer_clr_n;
            trg_en_q    <= (state_n == ST_ARMED);
            busy_q      <= (state_n != ST_IDLE);
            err_q       <= err_n;
            evt_q       <= evt_n;
            drop_q      <= drop_n;
        end
    end

    assign O_EXEC_STATE    = state_q;
    assign O_BL_CALC_START = bl_start_q;
    assign O_TIMER_CLR     = timer_clr_q;
    assign O_TRG_EN        = trg_en_q;
    assign O_BUSY          = busy_q;
    assign O_ERR_TIMEOUT   = err_q;
    assign O_EVENT_COUNT   = evt_q;
    assign O_DROP_COUNT    = drop_q;

endmodule

// File: tb/tb_trg_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trg_run_ctrl
//
// Scoreboard bench for trg_run_ctrl. Inputs are driven on the falling edge;
// a behavioural run model predicts the registered outputs for the following
// rising edge and queues them. A monitor pops one prediction after every
// rising edge and compares every output. Narrow counter widths are used so
// saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_trg_run_ctrl;

    localparam int BL_LEN   = 256;
    localparam int HO_LEN   = 8;
    localparam int EW       = 8;
    localparam int DW       = 4;
    localparam int EVT_MAX  = (1 << EW) - 1;
    localparam int DROP_MAX = (1 << DW) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_BASE  = 1;
    localparam int PH_ARMED = 2;
    localparam int PH_HOLD  = 3;

    logic          AXIS_ACLK = 1'b0;
    logic          AXIS_ARESETN = 1'b0;
    logic          RUN_START = 1'b0;
    logic          RUN_STOP = 1'b0;
    logic          BL_CALC_COMPLETE = 1'b0;
    logic          FIFO_FULL = 1'b0;
    logic          START_TRG = 1'b0;
    logic          S_AXIS_TVALID = 1'b0;
    logic [1:0]    O_EXEC_STATE;
    logic          O_BL_CALC_START;
    logic          O_TIMER_CLR;
    logic          O_TRG_EN;
    logic          O_BUSY;
    logic          O_ERR_TIMEOUT;
    logic [EW-1:0] O_EVENT_COUNT;
    logic [DW-1:0] O_DROP_COUNT;

    trg_run_ctrl #(
        .BL_TIMEOUT_LEN (BL_LEN),
        .HOLDOFF_LEN    (HO_LEN),
        .EVT_CNT_WIDTH  (EW),
        .DROP_CNT_WIDTH (DW)
    ) dut (
        .AXIS_ACLK        (AXIS_ACLK),
        .AXIS_ARESETN     (AXIS_ARESETN),
        .RUN_START        (RUN_START),
        .RUN_STOP         (RUN_STOP),
        .BL_CALC_COMPLETE (BL_CALC_COMPLETE),
        .FIFO_FULL        (FIFO_FULL),
        .START_TRG        (START_TRG),
        .S_AXIS_TVALID    (S_AXIS_TVALID),
        .O_EXEC_STATE     (O_EXEC_STATE),
        .O_BL_CALC_START  (O_BL_CALC_START),
        .O_TIMER_CLR      (O_TIMER_CLR),
        .O_TRG_EN         (O_TRG_EN),
        .O_BUSY           (O_BUSY),
        .O_ERR_TIMEOUT    (O_ERR_TIMEOUT),
        .O_EVENT_COUNT    (O_EVENT_COUNT),
        .O_DROP_COUNT     (O_DROP_COUNT)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    typedef struct packed {
        logic [1:0]    exec;
        logic          bl_start;
        logic          timer_clr;
        logic          trg_en;
        logic          busy;
        logic          err;
        logic [EW-1:0] evt;
        logic [DW-1:0] drop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Run model: phase plus plain integer tallies.
    int m_phase   = PH_IDLE;
    int m_samples = 0;
    int m_quiet   = 0;
    int m_evt     = 0;
    int m_drop    = 0;
    bit m_err     = 1'b0;

    function automatic logic [1:0] phase_code(input int p);
        case (p)
            PH_BASE:  return 2'b01;
            PH_ARMED: return 2'b11;
            PH_HOLD:  return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_samples = 0;
        m_quiet   = 0;
        m_evt     = 0;
        m_drop    = 0;
        m_err     = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the outputs the
    // run rules predict after the next rising edge.
    task automatic applyStimulus(input bit start, input bit stop, input bit complete,
                                 input bit full, input bit trg, input bit tvalid);
        bit pb;
        bit pc;
        exp_t e;
        @(negedge AXIS_ACLK);
        RUN_START        = start;
        RUN_STOP         = stop;
        BL_CALC_COMPLETE = complete;
        FIFO_FULL        = full;
        START_TRG        = trg;
        S_AXIS_TVALID    = tvalid;
        pb = 1'b0;
        pc = 1'b0;
        if (!AXIS_ARESETN) begin
            model_reset();
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (start && !stop) begin
                        m_phase   = PH_BASE;
                        pb        = 1'b1;
                        pc        = 1'b1;
                        m_evt     = 0;
                        m_drop    = 0;
                        m_err     = 1'b0;
                        m_samples = 0;
                    end
                end
                PH_BASE: begin
                    if (stop) begin
                        m_phase = PH_IDLE;
                    end else begin
                        if (tvalid) m_samples++;
                        if (m_samples == BL_LEN) begin
                            m_err     = 1'b1;
                            m_samples = 0;
`ifdef TRG_RUN_CTRL_AUTO_RETRY_EN
                            pb = 1'b1;
`else
                            m_phase = PH_IDLE;
`endif
                        end else if (complete) begin
                            m_phase = PH_ARMED;
                        end
                    end
                end
                PH_ARMED: begin
                    if (trg && m_evt < EVT_MAX) m_evt++;
                    if (stop) begin
                        m_phase = PH_IDLE;
                    end else if (full) begin
                        m_phase = PH_HOLD;
                        m_quiet = 0;
                    end
                end
                default: begin
                    if (trg && m_drop < DROP_MAX) m_drop++;
                    if (stop) begin
                        m_phase = PH_IDLE;
                    end else if (full) begin
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet == HO_LEN) m_phase = PH_ARMED;
                    end
                end
            endcase
        end
        e.exec      = phase_code(m_phase);
        e.bl_start  = pb;
        e.timer_clr = pc;
        e.trg_en    = (m_phase == PH_ARMED);
        e.busy      = (m_phase != PH_IDLE);
        e.err       = m_err;
        e.evt       = EW'(m_evt);
        e.drop      = DW'(m_drop);
        exp_q.push_back(e);
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge AXIS_ACLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("exec_state",  32'(O_EXEC_STATE),    32'(e.exec));
                checkOutput("bl_calc_start", 32'(O_BL_CALC_START), 32'(e.bl_start));
                checkOutput("timer_clr",   32'(O_TIMER_CLR),     32'(e.timer_clr));
                checkOutput("trg_en",      32'(O_TRG_EN),        32'(e.trg_en));
                checkOutput("busy",        32'(O_BUSY),          32'(e.busy));
                checkOutput("err_timeout", 32'(O_ERR_TIMEOUT),   32'(e.err));
                checkOutput("event_count", 32'(O_EVENT_COUNT),   32'(e.evt));
                checkOutput("drop_count",  32'(O_DROP_COUNT),    32'(e.drop));
            end
        end
    end

    initial begin : stimulus
        int cpct;
        bit full_lvl;

        // Reset held for a few cycles, then released.
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        AXIS_ARESETN = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // Start pulse, baseline completes at cycle 20.
        applyStimulus(1, 0, 0, 0, 0, 1);
        repeat (19) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1);

        // Five accepted triggers, then FIFO full for 10 cycles with 3 drops.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, (i == 2 || i == 5 || i == 8), 1);
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 1);

        // Glitch in the quiet window restarts the holdoff.
        applyStimulus(0, 0, 0, 1, 0, 1);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);

        // Baseline timeout with TVALID always high.
        applyStimulus(1, 0, 0, 0, 0, 1);
        repeat (262) applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);

        // Timeout with TVALID toggling every cycle.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 530; i++) applyStimulus(0, 0, 0, 0, 0, i[0]);
        applyStimulus(0, 1, 0, 0, 0, 0);

        // Stop together with FIFO full while armed; start and stop in idle.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomised run traffic with varying completion likelihood.
        full_lvl = 1'b0;
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0:       cpct = 0;
                1:       cpct = 3;
                default: cpct = 20;
            endcase
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(99, 0) < 10) full_lvl = ~full_lvl;
                applyStimulus($urandom_range(99, 0) < 5,
                              $urandom_range(999, 0) < 4,
                              $urandom_range(99, 0) < cpct,
                              full_lvl,
                              $urandom_range(99, 0) < 30,
                              $urandom_range(99, 0) < 60);
            end
        end
        applyStimulus(0, 1, 0, 0, 0, 0);

        // Counter saturation: 300 accepted triggers, 20 dropped triggers.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        repeat (300) applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (20) applyStimulus(0, 0, 0, 1, 1, 0);
        repeat (HO_LEN + 1) applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);

        // Reset asserted mid-cycle while armed: outputs clear without an edge.
        @(posedge AXIS_ACLK);
        #2;
        AXIS_ARESETN = 1'b0;
        #1;
        checkOutput("async_exec_state", 32'(O_EXEC_STATE), 32'd0);
        checkOutput("async_trg_en",     32'(O_TRG_EN),     32'd0);
        checkOutput("async_busy",       32'(O_BUSY),       32'd0);
        checkOutput("async_event_count", 32'(O_EVENT_COUNT), 32'd0);
        checkOutput("async_drop_count", 32'(O_DROP_COUNT), 32'd0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        AXIS_ARESETN = 1'b1;
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1);

        @(posedge AXIS_ACLK);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
